aes_key_expander: RTL and testbench

Iterative AES-128 key schedule that feeds the AddRoundKey stage. It latches a 128-bit cipher key on a start pulse and emits round keys 0..10, one per handshake. Each next round key is computed in a single cycle from the current one (RotWord/SubWord/Rcon), so the block never stores all 11 keys. It sits directly upstream of AddRoundKey; its round_key drives AddRoundKey's in2.

---
 rtl/aes_key_expander.sv | 94 +++++++++
 tb/tb_aes_key_expander.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule emitting round keys 0..10, one per handshake.
// Each next key is derived in one cycle from the current one, so only one key is ever stored.
module aes_key_expander #(
    parameter int NB = 128,
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NB-1:0] key_in,
    input  logic          rk_ready,
    output logic          rk_valid,
    output logic [NB-1:0] round_key,
    output logic [3:0]    rk_round,
    output logic          busy,
    output logic          done
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Byte r holds Rcon[r]; padded to 16 entries so any 4-bit round index reads a defined value.
    localparam logic [127:0] RCON = 128'h00010204_08102040_801b3600_00000000;

    function automatic logic [7:0] sub(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    typedef enum logic {IDLE, EMIT} state_t;

    state_t        state_q;
    logic [NB-1:0] key_q, key_d;
    logic [3:0]    round_q, round_d;
    logic          valid_q, busy_q, done_q;
    logic [31:0]   rot, t, n0, n1, n2, n3;

    always_comb begin
        round_d = round_q + 4'd1;
        rot     = {key_q[23:0], key_q[31:24]};
        t       = {sub(rot[31:24]), sub(rot[23:16]), sub(rot[15:8]), sub(rot[7:0])}
                  ^ {RCON[{~round_d, 3'b111} -: 8], 24'h0};
        n0      = key_q[127:96] ^ t;
        n1      = key_q[95:64] ^ n0;
        n2      = key_q[63:32] ^ n1;
        n3      = key_q[31:0] ^ n2;
        key_d   = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= EMIT;
                    key_q   <= key_in;
                    round_q <= '0;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                EMIT: if (rk_ready) begin
                    if (round_q == 4'(NR)) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        key_q   <= key_d;
                        round_q <= round_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_valid  = valid_q;
    assign round_key = key_q;
    assign rk_round  = round_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: scoreboard bench driving FIPS-197 and all-zero key schedules,
// backpressure, ignored restart, mid-run reset and start-in-done-cycle.
module tb_aes_key_expander;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, rk_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_valid, busy, done;
    logic [127:0] round_key;
    logic [3:0]   rk_round;

    aes_key_expander dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rk_ready(rk_ready),
        .rk_valid(rk_valid), .round_key(round_key), .rk_round(rk_round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         is_done;
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;

    logic [127:0] fips [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [127:0] zero_k [11] = '{
        128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input bit use_zero, input int n, input bit with_done);
        for (int i = 0; i < n; i++)
            sb.push_back('{1'b0, 4'(i), use_zero ? zero_k[i] : fips[i]});
        if (with_done) sb.push_back('{1'b1, 4'd0, 128'd0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("start_latency_valid", 128'(rk_valid), 128'd1);
        check("start_latency_round", 128'(rk_round), 128'd0);
    endtask

    task automatic wait_done(input string name, input bit random_ready);
        int n = 0;
        while (!done && n < 400) begin
            if (random_ready) rk_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check(name, 128'(done), 128'd1);
        rk_ready = 1'b1;
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n = 0;
        while (rk_round != r && n < 50) begin
            tick();
            n++;
        end
        check("reach_round", 128'(rk_round), 128'(r));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 128'(rk_valid), 128'd0);
        check({tag, "_key"}, round_key, 128'd0);
        check({tag, "_round"}, 128'(rk_round), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_done"}, 128'(done), 128'd0);
    endtask

    logic         hold_q = 1'b0;
    logic [127:0] held_key;
    logic [3:0]   held_rnd;
    exp_t         e;

    always @(negedge clk) begin
        if (!rst_n) hold_q = 1'b0;
        else begin
            if (rk_valid) check("done_with_valid", 128'(done), 128'd0);
            if (hold_q && rk_valid) begin
                check("hold_key", round_key, held_key);
                check("hold_round", 128'(rk_round), 128'(held_rnd));
            end
            hold_q   = rk_valid && !rk_ready;
            held_key = round_key;
            held_rnd = rk_round;
            if ((rk_valid && rk_ready) || done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: valid=%b done=%b round=%0d with nothing expected",
                             rk_valid, done, rk_round);
                end else begin
                    e = sb.pop_front();
                    check("output_kind_done", 128'(done), 128'(e.is_done));
                    if (e.is_done) check("busy_after_done", 128'(busy), 128'd0);
                    else begin
                        check("rk_round", 128'(rk_round), 128'(e.rnd));
                        check("round_key", round_key, e.key);
                    end
                end
            end
        end
    end

    initial begin
        int v;
        repeat (2) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // FIPS-197 key, rk_ready held high: 11 back-to-back keys then one done cycle
        rk_ready = 1'b1;
        push_seq(1'b0, 11, 1'b1);
        pulse_start(fips[0]);
        check("first_key", round_key, fips[0]);
        v = 0;
        while (rk_valid && v < 20) begin
            v++;
            tick();
        end
        check("consecutive_valid", 128'(v), 128'd11);
        check("done_pulse", 128'(done), 128'd1);
        check("busy_at_done", 128'(busy), 128'd0);
        check("last_key_kept", round_key, fips[10]);
        tick();
        check("done_one_cycle", 128'(done), 128'd0);

        // random backpressure
        push_seq(1'b0, 11, 1'b1);
        pulse_start(fips[0]);
        wait_done("backpressure_done", 1'b1);
        tick();

        // start re-pulsed with a different key during round 4 is ignored
        push_seq(1'b0, 11, 1'b1);
        pulse_start(fips[0]);
        wait_round(4'd4);
        key_in = {4{32'hdeadbeef}};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("busy_after_ignored_start", 128'(busy), 128'd1);
        wait_done("restart_ignored_done", 1'b0);

        // start in the done cycle launches the all-zero key expansion
        push_seq(1'b1, 11, 1'b1);
        key_in = '0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("done_cycle_start_valid", 128'(rk_valid), 128'd1);
        check("done_cycle_start_round", 128'(rk_round), 128'd0);
        check("done_cycle_start_key", round_key, 128'd0);
        wait_done("zero_key_done", 1'b0);
        tick();

        // reset while round 6 is presented abandons the run without done
        push_seq(1'b0, 6, 1'b0);
        pulse_start(fips[0]);
        wait_round(4'd6);
        rk_ready = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_zero_outputs("midrun_reset");
        rst_n = 1'b1;
        tick();
        check("no_done_after_reset", 128'(done), 128'd0);
        rk_ready = 1'b1;
        push_seq(1'b0, 11, 1'b1);
        pulse_start(fips[0]);
        check("post_reset_first_key", round_key, fips[0]);
        wait_done("post_reset_done", 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
